logic_gate_pipe: RTL and testbench
==================================

Name: logic_gate_pipe

Overview:
- Parametrised, pipelined multi-input bitwise logic gate: the successor to the single fixed-function NAND gate IP.
- Applies one of eight operations, chosen per transaction, across PORT_NUM input words of WIDTH bits.
- The result passes through an elastic valid/ready pipeline of STAGES registers.
- Sits between a producer and a consumer in lab datapaths that need a registered, back-pressurable gate array with a transaction count.

Parameters:
- PORT_NUM, 2, number of active input ports (legal range 2..8); only these ports are packed into din.
- WIDTH, 1, bit width of each input port and of the result (1..32).
- STAGES, 2, number of pipeline registers from acceptance to output (1..4).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- din, input, PORT_NUM*WIDTH, packed operands; port k occupies bits [k*WIDTH +: WIDTH].
- op, input, 3, operation select, sampled together with din.
- in_valid, input, 1, producer offers din/op this cycle.
- in_ready, output, 1, block accepts din/op this cycle.
- q, output, WIDTH, result at pipeline head.
- out_valid, output, 1, q holds a valid result.
- out_ready, input, 1, consumer takes q this cycle.
- done_cnt, output, CNT_W, number of results delivered (out_valid & out_ready).

Behaviour:
- Reset (async, rst=1):
  - all stage valid bits clear; out_valid=0; q=0; done_cnt=0.
  - in_ready reflects the empty pipe, so it is 1 while reset is held and out_ready does not matter.
  - Reset mid-operation discards every in-flight result without delivering it; done_cnt does not increment for discarded results.
- op encoding, bitwise across ports 0..PORT_NUM-1:
  - 000 AND; 001 NAND; 010 OR; 011 NOR; 100 XOR (odd parity per bit); 101 XNOR.
  - 110 PASS (port 0 unchanged); 111 NOT (~port 0).
  - Ports at or above PORT_NUM do not exist and never affect q.
- Acceptance: a transfer occurs when in_valid & in_ready. The function result is computed combinationally from din/op and written into stage 0 in the same edge. op is captured per transaction, so consecutive transfers may use different ops.
- Pipeline: stages 0..STAGES-1, each holding one valid bit and one WIDTH-bit data word. Stage STAGES-1 drives q/out_valid.
- Ready chain:
  - ready[STAGES] = out_ready.
  - ready[i] = !valid[i] | ready[i+1].
  - in_ready = ready[0].
  - The chain is combinational, giving full throughput of 1 result per cycle under continuous out_ready.
- Stage i update, when ready[i] is true:
  - valid[i] <= valid[i-1].
  - data[i] <= data[i-1].
  - Stage 0 takes in_valid and the computed result.
  - Otherwise the stage holds its contents.
- Latency: a transfer accepted at edge n produces out_valid=1 with the result after edge n+STAGES-1, i.e. visible in cycle n+STAGES-1 counting the acceptance edge as stage 0 load. With STAGES=1, q is valid the cycle after acceptance.
- Backpressure:
  - While out_valid & !out_ready, q and out_valid hold stable; data never changes under a pending valid.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
  - Capacity is STAGES results. With the pipe full and out_ready=0, in_ready=0.
- Simultaneous events:
  - A delivery and an acceptance in the same cycle are both honoured.
  - With a full pipe and out_ready=1, in_ready=1 in that cycle.
- done_cnt: increments by 1 on each out_valid & out_ready edge and wraps from 2^CNT_W-1 to 0.
- Idle: when in_valid=0 bubbles propagate; q retains its last value when out_valid=0 (not cleared).

Test Plan:
1. Reset then function sweep, PORT_NUM=3, WIDTH=4, STAGES=2, out_ready=1, din={4'hC,4'hA,4'hF} (port2..port0), op 000..111 on consecutive cycles -> q sequence 8, 7, F, 0, 9, 6, F, 0 (op 110/111 give port 0 = F / ~F = 0), each two cycles after issue, one per cycle; done_cnt=8.
2. Backpressure, STAGES=2, out_ready=0, stream 4 transfers of op=010 -> only 2 accepted, in_ready=0 from the third; q and out_valid stable. Raise out_ready -> remaining transfers drain in order, no loss or duplication.
3. Simultaneous, full pipe, in_valid=1, out_ready=1 in the same cycle -> in_ready=1, one delivery and one acceptance on the edge, occupancy stays 2.
4. Async reset mid-flight, pipe holding 2 results, assert rst between clock edges -> out_valid, q, done_cnt go 0 immediately; after release no stale results appear.
5. Counter wrap, CNT_W=4, deliver 17 results -> done_cnt reads 1.
6. PORT_NUM=8, WIDTH=1, XOR of din=8'b1011_0001 -> q=0; XNOR -> q=1; STAGES=1 gives result one cycle after acceptance.

Source files
------------

// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_gate_pipe
// Purpose  : Eight-function bitwise gate over PORT_NUM words feeding an
//            elastic valid/ready pipeline, with a delivered-result counter.
// Revision : 1.0 - initial release
// ============================================================================
module logic_gate_pipe #(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 1,
  parameter int STAGES   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORT_NUM*WIDTH-1:0] din,
  input  logic [2:0]                op,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          done_cnt
);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_NAND = 3'b001;
  localparam logic [2:0] c_OP_OR   = 3'b010;
  localparam logic [2:0] c_OP_NOR  = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_XNOR = 3'b101;
  localparam logic [2:0] c_OP_PASS = 3'b110;

  logic [WIDTH-1:0]  w_and;
  logic [WIDTH-1:0]  w_or;
  logic [WIDTH-1:0]  w_xor;
  logic [WIDTH-1:0]  w_port0;
  logic [WIDTH-1:0]  w_result;
  logic [STAGES-1:0] w_ready;
  logic [STAGES-1:0] w_up_valid;
  logic [WIDTH-1:0]  w_up_data [STAGES];
  logic              w_deliver;

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [CNT_W-1:0]  r_done_cnt;

  // Reductions span only the ports that exist.
  always_comb begin
    w_and = '1;
    w_or  = '0;
    w_xor = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      w_and = w_and & din[k*WIDTH +: WIDTH];
      w_or  = w_or  | din[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ din[k*WIDTH +: WIDTH];
    end
  end

  assign w_port0 = din[WIDTH-1:0];

  always_comb begin
    w_result = ~w_port0;
    case (op)
      c_OP_AND:  w_result = w_and;
      c_OP_NAND: w_result = ~w_and;
      c_OP_OR:   w_result = w_or;
      c_OP_NOR:  w_result = ~w_or;
      c_OP_XOR:  w_result = w_xor;
      c_OP_XNOR: w_result = ~w_xor;
      c_OP_PASS: w_result = w_port0;
      default:   w_result = ~w_port0;
    endcase
  end

  // A stage may load when it is empty or everything ahead of it moves.
  always_comb begin : p_ready
    logic v_rdy;
    w_ready = '0;
    v_rdy   = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      v_rdy      = !r_valid[i] | v_rdy;
      w_ready[i] = v_rdy;
    end
  end

  always_comb begin
    w_up_valid[0] = in_valid;
    w_up_data[0]  = w_result;
    for (int i = 1; i < STAGES; i++) begin
      w_up_valid[i] = r_valid[i-1];
      w_up_data[i]  = r_data[i-1];
    end
  end

  // Data loads only with a valid word so q keeps its last result when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_ready[i]) begin
          r_valid[i] <= w_up_valid[i];
          if (w_up_valid[i]) begin
            r_data[i] <= w_up_data[i];
          end
        end
      end
    end
  end

  assign w_deliver = r_valid[STAGES-1] & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_cnt <= '0;
    end else if (w_deliver) begin
      r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_ready[0];
  assign q         = r_data[STAGES-1];
  assign out_valid = r_valid[STAGES-1];
  assign done_cnt  = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_gate_pipe
// Purpose  : Directed and random checks of logic_gate_pipe in two configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_gate_pipe;

  localparam int A_P  = 3;
  localparam int A_W  = 4;
  localparam int A_ST = 2;
  localparam int A_CW = 4;

  logic clk;
  logic rst;

  logic [A_P*A_W-1:0] a_din;
  logic [2:0]         a_op;
  logic               a_in_valid;
  logic               a_in_ready;
  logic [A_W-1:0]     a_q;
  logic               a_out_valid;
  logic               a_out_ready;
  logic [A_CW-1:0]    a_done_cnt;

  logic [7:0]  b_din;
  logic [2:0]  b_op;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [0:0]  b_q;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [15:0] b_done_cnt;

  logic_gate_pipe #(.PORT_NUM(A_P), .WIDTH(A_W), .STAGES(A_ST), .CNT_W(A_CW)) u_dut_a (
    .clk(clk), .rst(rst), .din(a_din), .op(a_op), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .q(a_q), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .done_cnt(a_done_cnt)
  );

  logic_gate_pipe #(.PORT_NUM(8), .WIDTH(1), .STAGES(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .din(b_din), .op(b_op), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .q(b_q), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .done_cnt(b_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q [$];
  int          exp_age [$];
  int          exp_cnt;
  logic [31:0] last_head;
  logic        last_acc;
  logic [31:0] cap [$];
  logic [3:0]  sweep_exp [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per bit: count ones over the ports, then apply the gate rule.
  function automatic logic [31:0] ref_fn(input logic [63:0] d, input int p, input int w,
                                         input logic [2:0] o);
    logic [31:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < w; b++) begin
      ones = 0;
      for (int k = 0; k < p; k++) ones += int'(d[k*w+b]);
      case (o)
        3'd0: r[b] = (ones == p);
        3'd1: r[b] = (ones != p);
        3'd2: r[b] = (ones > 0);
        3'd3: r[b] = (ones == 0);
        3'd4: r[b] = ((ones % 2) == 1);
        3'd5: r[b] = ((ones % 2) == 0);
        3'd6: r[b] = d[b];
        default: r[b] = ~d[b];
      endcase
    end
    return r;
  endfunction

  // One cycle of DUT A: entered at a negedge with inputs already driven.
  // An entry is at the head once it has aged STAGES-1 edges and is oldest.
  task automatic step_a();
    logic        exp_rdy, exp_ov, del;
    logic [31:0] exp_qv, res;
    #1;
    exp_rdy = (exp_q.size() < A_ST) || a_out_ready;
    exp_ov  = (exp_q.size() > 0) && (exp_age[0] >= A_ST - 1);
    exp_qv  = exp_ov ? exp_q[0] : last_head;
    check("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
    check("a_out_valid", 32'(a_out_valid), 32'(exp_ov));
    check("a_q", 32'(a_q), exp_qv);
    check("a_done_cnt", 32'(a_done_cnt), 32'(exp_cnt));
    if (exp_ov) last_head = exp_q[0];
    last_acc = a_in_valid && exp_rdy;
    del      = exp_ov && a_out_ready;
    if (del) cap.push_back(32'(a_q));
    res = ref_fn(64'(a_din), A_P, A_W, a_op);
    @(posedge clk);
    if (del) begin
      void'(exp_q.pop_front());
      void'(exp_age.pop_front());
      exp_cnt = (exp_cnt + 1) % (1 << A_CW);
    end
    for (int i = 0; i < exp_age.size(); i++) exp_age[i]++;
    if (last_acc) begin
      exp_q.push_back(res);
      exp_age.push_back(0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic        pv;
    logic [31:0] pq;
    int          idx;
    n_vec = 0; n_err = 0; exp_cnt = 0; last_head = '0; last_acc = 1'b0;
    sweep_exp = '{4'h8, 4'h7, 4'hF, 4'h0, 4'h9, 4'h6, 4'hF, 4'h0};
    rst = 1'b0;
    a_din = '0; a_op = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_din = '0; b_op = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_a_out_valid", 32'(a_out_valid), 0);
    check("rst_a_q", 32'(a_q), 0);
    check("rst_a_done_cnt", 32'(a_done_cnt), 0);
    check("rst_a_in_ready", 32'(a_in_ready), 1);
    check("rst_b_out_valid", 32'(b_out_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // 8-port 1-bit XOR/XNOR with a single stage.
    b_out_ready = 1'b1; b_din = 8'b1011_0001; b_op = 3'b100; b_in_valid = 1'b1;
    #1 check("b_in_ready", 32'(b_in_ready), 1);
    @(negedge clk); b_op = 3'b101;
    #1;
    check("b_xor_valid", 32'(b_out_valid), 1);
    check("b_xor_q", 32'(b_q), 0);
    @(negedge clk); b_in_valid = 1'b0;
    #1;
    check("b_xnor_valid", 32'(b_out_valid), 1);
    check("b_xnor_q", 32'(b_q), 1);
    @(negedge clk);
    #1;
    check("b_idle_valid", 32'(b_out_valid), 0);
    check("b_idle_q_hold", 32'(b_q), 1);
    check("b_done_cnt", 32'(b_done_cnt), 2);
    pq = 32'd1;
    for (int i = 0; i < 30; i++) begin
      b_in_valid = 1'($urandom);
      b_din      = 8'($urandom);
      b_op       = 3'($urandom);
      pv = b_in_valid;
      if (b_in_valid) pq = ref_fn(64'(b_din), 8, 1, b_op);
      @(negedge clk);
      #1;
      check("b_rand_valid", 32'(b_out_valid), 32'(pv));
      check("b_rand_q", 32'(b_q), pq);
    end
    b_in_valid = 1'b0;
    @(negedge clk);

    // Function sweep, one op per cycle.
    cap.delete();
    a_out_ready = 1'b1;
    a_din = {4'hC, 4'hA, 4'hF};
    for (int o = 0; o < 8; o++) begin
      a_op = 3'(o); a_in_valid = 1'b1;
      step_a();
    end
    a_in_valid = 1'b0;
    repeat (3) step_a();
    for (int i = 0; i < 8; i++) check("sweep_q", (i < cap.size()) ? cap[i] : 32'hDEAD, 32'(sweep_exp[i]));
    check("sweep_done_cnt", 32'(a_done_cnt), 8);

    // Backpressure: producer holds each word until it is taken.
    a_op = 3'b010; idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_out_ready = (cyc >= 5);
      if (idx < 4) begin
        if (cyc == 0 || last_acc) a_din = 12'($urandom);
        a_in_valid = 1'b1;
      end else begin
        a_in_valid = 1'b0;
      end
      step_a();
      if (a_in_valid && last_acc) idx++;
    end

    // Full pipe with delivery and acceptance on the same edge.
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_din = 12'($urandom); a_op = 3'($urandom);
      step_a();
    end
    a_out_ready = 1'b1; a_din = 12'($urandom);
    #1 check("full_in_ready", 32'(a_in_ready), 1);
    #1;
    @(negedge clk);
    // Realigned; model has not advanced, so replay the cycle through the model.
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    exp_q.delete(); exp_age.delete();
    rst = 1'b1;
    #1 rst = 1'b0;
    exp_cnt = 0; last_head = '0;
    @(negedge clk);
    a_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_out_ready = 1'b0; a_din = 12'($urandom); a_op = 3'($urandom);
      step_a();
    end
    a_out_ready = 1'b1; a_din = 12'($urandom);
    step_a();
    a_in_valid = 1'b0;
    step_a();
    repeat (3) step_a();

    // Asynchronous reset with two results in flight.
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    repeat (2) begin
      a_din = 12'($urandom); a_op = 3'($urandom);
      step_a();
    end
    a_in_valid = 1'b0;
    step_a();
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(a_out_valid), 0);
    check("arst_q", 32'(a_q), 0);
    check("arst_done_cnt", 32'(a_done_cnt), 0);
    check("arst_in_ready", 32'(a_in_ready), 1);
    check("arst_b_done_cnt", 32'(b_done_cnt), 0);
    exp_q.delete(); exp_age.delete(); exp_cnt = 0; last_head = '0;
    @(negedge clk);
    rst = 1'b0; a_out_ready = 1'b1;
    repeat (4) step_a();

    // Counter wrap at 2^4 after 17 deliveries.
    a_in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      a_din = 12'($urandom); a_op = 3'($urandom);
      step_a();
    end
    a_in_valid = 1'b0;
    repeat (3) step_a();
    check("wrap_done_cnt", 32'(a_done_cnt), 1);

    // Random traffic on both handshakes.
    for (int i = 0; i < 300; i++) begin
      a_in_valid  = ($urandom % 4) != 0;
      a_out_ready = ($urandom % 3) != 0;
      a_din       = 12'($urandom);
      a_op        = 3'($urandom);
      step_a();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (4) step_a();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
